// File: rtl/vgatoxy.sv
// Raster-to-cell grid decoder with a 2-stage raster pipeline and a pointer
// conversion FSM that resolves a pixel pointer to a cell once per frame boundary.
module vgatoxy #(
    parameter int unsigned CELL_LOG2 = 5,
    parameter int unsigned H_ACTIVE  = 640,
    parameter int unsigned V_ACTIVE  = 480
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] hcount,
    input  logic [10:0] vcount,
    input  logic        blank,
    input  logic [10:0] ptr_h,
    input  logic [10:0] ptr_v,
    input  logic        ptr_req,
    output logic        ptr_busy,
    output logic [4:0]  cell_x,
    output logic [3:0]  cell_y,
    output logic [4:0]  off_x,
    output logic [4:0]  off_y,
    output logic        scan_valid,
    output logic        scan_interior,
    output logic [4:0]  sel_x,
    output logic [3:0]  sel_y,
    output logic        sel_valid,
    output logic        sel_err,
    output logic        sel_done
);

    localparam int unsigned CW = 11;
    localparam logic [CW-1:0] OFF_MASK = CW'((1 << CELL_LOG2) - 1);

    typedef enum logic [1:0] {IDLE, WAIT_FRAME, CONVERT, DONE} state_t;

    state_t state_q, state_d;

    logic          s1_valid_q, s1_valid_d;
    logic [4:0]    s1_cx_q, s1_cx_d;
    logic [3:0]    s1_cy_q, s1_cy_d;
    logic [4:0]    s1_ox_q, s1_ox_d;
    logic [4:0]    s1_oy_q, s1_oy_d;

    logic          scan_valid_q, scan_valid_d;
    logic          scan_interior_q, scan_interior_d;
    logic [4:0]    cell_x_q, cell_x_d;
    logic [3:0]    cell_y_q, cell_y_d;
    logic [4:0]    off_x_q, off_x_d;
    logic [4:0]    off_y_q, off_y_d;

    logic [CW-1:0] ptr_h_q, ptr_h_d;
    logic [CW-1:0] ptr_v_q, ptr_v_d;
    logic          ptr_busy_q, ptr_busy_d;
    logic [4:0]    sel_x_q, sel_x_d;
    logic [3:0]    sel_y_q, sel_y_d;
    logic          sel_valid_q, sel_valid_d;
    logic          sel_err_q, sel_err_d;
    logic          sel_done_q, sel_done_d;

    logic          in_grid;
    logic          boundary;
    logic          ptr_in_range;

    // Raster pipeline: stage 1 decodes fields, stage 2 derives the interior flag
    always_comb begin
        in_grid         = !blank && (hcount < CW'(H_ACTIVE)) && (vcount < CW'(V_ACTIVE));
        s1_valid_d      = in_grid;
        s1_cx_d         = in_grid ? 5'(hcount >> CELL_LOG2) : 5'd0;
        s1_cy_d         = in_grid ? 4'(vcount >> CELL_LOG2) : 4'd0;
        s1_ox_d         = in_grid ? 5'(hcount & OFF_MASK)   : 5'd0;
        s1_oy_d         = in_grid ? 5'(vcount & OFF_MASK)   : 5'd0;
        scan_valid_d    = s1_valid_q;
        scan_interior_d = s1_valid_q && (s1_ox_q != 5'd0) && (s1_oy_q != 5'd0);
        cell_x_d        = s1_cx_q;
        cell_y_d        = s1_cy_q;
        off_x_d         = s1_ox_q;
        off_y_d         = s1_oy_q;
    end

    // Pointer FSM: next state and registered outputs
    always_comb begin
        state_d      = state_q;
        ptr_h_d      = ptr_h_q;
        ptr_v_d      = ptr_v_q;
        sel_x_d      = sel_x_q;
        sel_y_d      = sel_y_q;
        sel_valid_d  = sel_valid_q;
        sel_err_d    = sel_err_q;
        boundary     = (vcount == CW'(V_ACTIVE)) && (hcount == '0);
        ptr_in_range = (ptr_h_q < CW'(H_ACTIVE)) && (ptr_v_q < CW'(V_ACTIVE));
        unique case (state_q)
            IDLE: begin
                if (ptr_req) begin
                    ptr_h_d = ptr_h;
                    ptr_v_d = ptr_v;
                    state_d = WAIT_FRAME;
                end
            end
            WAIT_FRAME: begin
                if (boundary) state_d = CONVERT;
            end
            CONVERT: begin
                if (ptr_in_range) begin
                    sel_x_d     = 5'(ptr_h_q >> CELL_LOG2);
                    sel_y_d     = 4'(ptr_v_q >> CELL_LOG2);
                    sel_valid_d = 1'b1;
                    sel_err_d   = 1'b0;
                end else begin
                    sel_err_d   = 1'b1;
                end
                state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        ptr_busy_d = (state_d != IDLE);
        sel_done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            s1_valid_q      <= 1'b0;
            s1_cx_q         <= '0;
            s1_cy_q         <= '0;
            s1_ox_q         <= '0;
            s1_oy_q         <= '0;
            scan_valid_q    <= 1'b0;
            scan_interior_q <= 1'b0;
            cell_x_q        <= '0;
            cell_y_q        <= '0;
            off_x_q         <= '0;
            off_y_q         <= '0;
            ptr_h_q         <= '0;
            ptr_v_q         <= '0;
            ptr_busy_q      <= 1'b0;
            sel_x_q         <= '0;
            sel_y_q         <= '0;
            sel_valid_q     <= 1'b0;
            sel_err_q       <= 1'b0;
            sel_done_q      <= 1'b0;
        end else begin
            state_q         <= state_d;
            s1_valid_q      <= s1_valid_d;
            s1_cx_q         <= s1_cx_d;
            s1_cy_q         <= s1_cy_d;
            s1_ox_q         <= s1_ox_d;
            s1_oy_q         <= s1_oy_d;
            scan_valid_q    <= scan_valid_d;
            scan_interior_q <= scan_interior_d;
            cell_x_q        <= cell_x_d;
            cell_y_q        <= cell_y_d;
            off_x_q         <= off_x_d;
            off_y_q         <= off_y_d;
            ptr_h_q         <= ptr_h_d;
            ptr_v_q         <= ptr_v_d;
            ptr_busy_q      <= ptr_busy_d;
            sel_x_q         <= sel_x_d;
            sel_y_q         <= sel_y_d;
            sel_valid_q     <= sel_valid_d;
            sel_err_q       <= sel_err_d;
            sel_done_q      <= sel_done_d;
        end
    end

    assign scan_valid    = scan_valid_q;
    assign scan_interior = scan_interior_q;
    assign cell_x        = cell_x_q;
    assign cell_y        = cell_y_q;
    assign off_x         = off_x_q;
    assign off_y         = off_y_q;
    assign ptr_busy      = ptr_busy_q;
    assign sel_x         = sel_x_q;
    assign sel_y         = sel_y_q;
    assign sel_valid     = sel_valid_q;
    assign sel_err       = sel_err_q;
    assign sel_done      = sel_done_q;

endmodule

// File: tb/tb_vgatoxy.sv
// Directed-vector bench for vgatoxy: raster pipeline decode and pointer conversion FSM.
module tb_vgatoxy;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] hcount, vcount, ptr_h, ptr_v;
    logic        blank, ptr_req;
    logic        ptr_busy, scan_valid, scan_interior, sel_valid, sel_err, sel_done;
    logic [4:0]  cell_x, off_x, off_y, sel_x;
    logic [3:0]  cell_y, sel_y;

    int n_vec  = 0;
    int n_miss = 0;
    int n_done = 0;

    vgatoxy dut (
        .clk(clk), .rst(rst), .hcount(hcount), .vcount(vcount), .blank(blank),
        .ptr_h(ptr_h), .ptr_v(ptr_v), .ptr_req(ptr_req), .ptr_busy(ptr_busy),
        .cell_x(cell_x), .cell_y(cell_y), .off_x(off_x), .off_y(off_y),
        .scan_valid(scan_valid), .scan_interior(scan_interior),
        .sel_x(sel_x), .sel_y(sel_y), .sel_valid(sel_valid), .sel_err(sel_err),
        .sel_done(sel_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (sel_done) n_done++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one frame-boundary cycle, then move the raster off it
    task automatic boundary();
        hcount = 11'd0;
        vcount = 11'd480;
        tick();
        hcount = 11'd1;
        vcount = 11'd0;
    endtask

    task automatic request(input logic [10:0] h, input logic [10:0] v);
        ptr_h   = h;
        ptr_v   = v;
        ptr_req = 1'b1;
        tick();
        ptr_req = 1'b0;
    endtask

    // Raster vectors: hcount, vcount, blank -> cell_x, cell_y, off_x, off_y, valid, interior
    localparam int NR = 6;
    logic [10:0] rv_h [NR] = '{11'd100, 11'd96, 11'd640, 11'd639, 11'd100, 11'd64};
    logic [10:0] rv_v [NR] = '{11'd70,  11'd70, 11'd70,  11'd479, 11'd70,  11'd480};
    logic        rv_b [NR] = '{1'b0,    1'b0,   1'b0,    1'b0,    1'b1,    1'b0};
    logic [4:0]  rx_cx[NR] = '{5'd3,    5'd3,   5'd0,    5'd19,   5'd0,    5'd0};
    logic [3:0]  rx_cy[NR] = '{4'd2,    4'd2,   4'd0,    4'd14,   4'd0,    4'd0};
    logic [4:0]  rx_ox[NR] = '{5'd4,    5'd0,   5'd0,    5'd31,   5'd0,    5'd0};
    logic [4:0]  rx_oy[NR] = '{5'd6,    5'd6,   5'd0,    5'd31,   5'd0,    5'd0};
    logic        rx_v [NR] = '{1'b1,    1'b1,   1'b0,    1'b1,    1'b0,    1'b0};
    logic        rx_i [NR] = '{1'b1,    1'b0,   1'b0,    1'b1,    1'b0,    1'b0};

    initial begin
        rst = 1'b1; hcount = 11'd100; vcount = 11'd70; blank = 1'b0;
        ptr_h = 11'd0; ptr_v = 11'd0; ptr_req = 1'b0;
        tick(); tick(); tick();
        chk("rst_scan_valid", 32'(scan_valid), 32'd0);
        chk("rst_cell_x", 32'(cell_x), 32'd0);
        chk("rst_busy", 32'(ptr_busy), 32'd0);
        chk("rst_sel_valid", 32'(sel_valid), 32'd0);
        rst = 1'b0;

        // Pipeline latency: one edge after reset release the output is still cleared
        tick();
        chk("lat1_scan_valid", 32'(scan_valid), 32'd0);
        tick();
        chk("lat2_scan_valid", 32'(scan_valid), 32'd1);
        chk("lat2_cell_x", 32'(cell_x), 32'd3);

        for (int i = 0; i < NR; i++) begin
            hcount = rv_h[i]; vcount = rv_v[i]; blank = rv_b[i];
            tick(); tick();
            chk($sformatf("r%0d_cell_x", i), 32'(cell_x), 32'(rx_cx[i]));
            chk($sformatf("r%0d_cell_y", i), 32'(cell_y), 32'(rx_cy[i]));
            chk($sformatf("r%0d_off_x", i), 32'(off_x), 32'(rx_ox[i]));
            chk($sformatf("r%0d_off_y", i), 32'(off_y), 32'(rx_oy[i]));
            chk($sformatf("r%0d_valid", i), 32'(scan_valid), 32'(rx_v[i]));
            chk($sformatf("r%0d_interior", i), 32'(scan_interior), 32'(rx_i[i]));
        end
        hcount = 11'd1; vcount = 11'd0; blank = 1'b0;

        // In-range conversion at the far corner, with a busy request ignored
        request(11'd639, 11'd479);
        chk("c1_busy", 32'(ptr_busy), 32'd1);
        tick();
        request(11'd32, 11'd64);
        tick(); tick();
        chk("c1_wait_busy", 32'(ptr_busy), 32'd1);
        chk("c1_wait_nodone", 32'(n_done), 32'd0);
        boundary();
        chk("c1_conv_done", 32'(sel_done), 32'd0);
        tick();
        chk("c1_done", 32'(sel_done), 32'd1);
        chk("c1_done_busy", 32'(ptr_busy), 32'd1);
        chk("c1_sel_x", 32'(sel_x), 32'd19);
        chk("c1_sel_y", 32'(sel_y), 32'd14);
        chk("c1_sel_valid", 32'(sel_valid), 32'd1);
        chk("c1_sel_err", 32'(sel_err), 32'd0);
        tick();
        chk("c1_idle_busy", 32'(ptr_busy), 32'd0);
        chk("c1_idle_done", 32'(sel_done), 32'd0);
        tick(); tick(); tick();
        chk("c1_done_count", 32'(n_done), 32'd1);
        chk("c1_hold_x", 32'(sel_x), 32'd19);

        // Out-of-range request keeps prior cell, raises error
        request(11'd700, 11'd10);
        boundary();
        tick();
        chk("c2_done", 32'(sel_done), 32'd1);
        chk("c2_sel_err", 32'(sel_err), 32'd1);
        chk("c2_sel_x", 32'(sel_x), 32'd19);
        chk("c2_sel_y", 32'(sel_y), 32'd14);
        chk("c2_sel_valid", 32'(sel_valid), 32'd1);

        // Request accepted the cycle after DONE, latched on a boundary cycle: waits a frame
        tick();
        hcount = 11'd0; vcount = 11'd480;
        request(11'd32, 11'd64);
        hcount = 11'd1; vcount = 11'd0;
        chk("c3_accept_busy", 32'(ptr_busy), 32'd1);
        tick(); tick(); tick();
        chk("c3_still_busy", 32'(ptr_busy), 32'd1);
        chk("c3_no_early_done", 32'(n_done), 32'd2);
        boundary();
        tick();
        chk("c3_done", 32'(sel_done), 32'd1);
        chk("c3_edge_x", 32'(sel_x), 32'd1);
        chk("c3_edge_y", 32'(sel_y), 32'd2);
        chk("c3_err_clr", 32'(sel_err), 32'd0);
        tick();

        // Reset while waiting for the frame aborts the conversion
        request(11'd100, 11'd100);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("c4_busy", 32'(ptr_busy), 32'd0);
        chk("c4_sel_x", 32'(sel_x), 32'd0);
        chk("c4_sel_y", 32'(sel_y), 32'd0);
        chk("c4_sel_valid", 32'(sel_valid), 32'd0);
        chk("c4_sel_done", 32'(sel_done), 32'd0);
        chk("c4_scan_valid", 32'(scan_valid), 32'd0);
        boundary();
        tick(); tick();
        chk("c4_no_done", 32'(n_done), 32'd3);
        chk("c4_idle_busy", 32'(ptr_busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/vgatoxy.md
VGATOXY -- requirements
Module: vgatoxy

Interface
REQ-001 Parameter CELL_LOG2, default 5, SHALL set the cell edge as 2^CELL_LOG2 pixels (32).
REQ-002 Parameter H_ACTIVE, default 640, SHALL set the visible pixels per line.
REQ-003 Parameter V_ACTIVE, default 480, SHALL set the visible lines per frame.
REQ-004 The block SHALL have one clock; reset is synchronous and active-high, with ports:
- clk  in  1  pixel clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
REQ-005 The block SHALL have the following data ports:
- hcount  in  11  raster column, advances one per clk
- vcount  in  11  raster line
- blank  in  1  raster blanking
- ptr_h  in  11  pointer pixel column
- ptr_v  in  11  pointer pixel line
- ptr_req  in  1  conversion request strobe
- ptr_busy  out  1  conversion in progress
- cell_x  out  5  raster cell column
- cell_y  out  4  raster cell row
- off_x  out  5  pixel offset inside cell, horizontal
- off_y  out  5  pixel offset inside cell, vertical
- scan_valid  out  1  raster pixel inside visible grid
- scan_interior  out  1  pixel strictly inside a cell (not on a cell edge line)
- sel_x  out  5  converted pointer cell column
- sel_y  out  4  converted pointer cell row
- sel_valid  out  1  a successful conversion has occurred since reset
- sel_err  out  1  last conversion was out of range
- sel_done  out  1  one-cycle conversion-complete pulse

Function
REQ-006 The raster path SHALL be a 2-stage registered pipeline: outputs correspond to the hcount/vcount/blank sampled 2 clk earlier.
REQ-007 The raster path SHALL compute cell_x = hcount>>5 truncated to 5 bits, off_x = hcount[4:0], cell_y = vcount>>5 truncated to 4 bits, and off_y = vcount[4:0].
REQ-008 scan_valid SHALL be 1 iff !blank && hcount<H_ACTIVE && vcount<V_ACTIVE; when scan_valid=0, cell_x, cell_y, off_x and off_y SHALL be 0.
REQ-009 scan_interior SHALL be 1 iff scan_valid && off_x!=0 && off_y!=0, so that pixel 32*n is treated as an edge.
REQ-010 The pointer FSM SHALL have the states IDLE, WAIT_FRAME, CONVERT and DONE.
REQ-011 In IDLE, ptr_req=1 SHALL latch ptr_h/ptr_v and enter WAIT_FRAME; ptr_busy SHALL be 1 from the next cycle through the DONE cycle.
REQ-012 ptr_req asserted in any state other than IDLE SHALL be ignored, with no queuing.
REQ-013 WAIT_FRAME SHALL advance to CONVERT on the first cycle where raw vcount==V_ACTIVE && hcount==0.
REQ-014 If a request is latched on the boundary cycle itself, WAIT_FRAME SHALL still wait for the next boundary.
REQ-015 In CONVERT, an in-range pointer (latched ptr_h<H_ACTIVE && ptr_v<V_ACTIVE) SHALL give sel_x=ptr_h>>5, sel_y=ptr_v>>5, sel_err=0 and sel_valid=1.
REQ-016 In CONVERT, an out-of-range pointer SHALL give sel_err=1 and leave sel_x, sel_y and sel_valid unchanged.
REQ-017 A pointer exactly on a cell edge (a multiple of 32) SHALL map to the right/lower cell.
REQ-018 DONE SHALL assert sel_done for exactly one cycle, then return to IDLE, where a new ptr_req is accepted.
REQ-019 sel_x, sel_y, sel_err and sel_valid SHALL hold their values between conversions.

Reset
REQ-020 When rst=1 on a rising edge, the FSM SHALL enter IDLE and every output SHALL be 0, including pipeline registers, regardless of the in-flight state.
REQ-021 A conversion in progress at reset SHALL be aborted with no sel_done pulse.
REQ-022 The raster outputs SHALL be valid from the 2nd clk after rst deasserts.

Verification
REQ-023 Raster pipeline: hcount=100, vcount=70, blank=0 -> 2 clk later cell_x=3, off_x=4, cell_y=2, off_y=6, scan_valid=1, scan_interior=1.
REQ-024 Cell edges and limits: hcount=96, vcount=70 -> scan_interior=0 with cell_x=3; hcount=640 -> scan_valid=0 and all raster outputs 0.
REQ-025 Pointer conversion: ptr_h=639, ptr_v=479, ptr_req -> busy until the frame boundary, then sel_x=19, sel_y=14, sel_valid=1, sel_err=0, one sel_done pulse.
REQ-026 Out-of-range pointer: ptr_h=700 after a valid conversion -> sel_err=1, sel_x/sel_y keep their prior values, sel_valid stays 1.
REQ-027 Busy request: a second ptr_req during WAIT_FRAME -> ignored, exactly one sel_done; a new ptr_req the cycle after DONE is accepted.
REQ-028 Reset mid-operation: rst in WAIT_FRAME -> next cycle all outputs 0, state IDLE, no sel_done.
